// File: rtl/fifo_arb_pkg.sv
// Shared sizing helpers and types for the FIFO push arbiter.
//   credit_w(depth) : bits needed to hold 0..depth free slots
//   idx_w(nreq)     : bits needed to name one of nreq requesters
//   credit_t / req_idx_t : types at the default DEPTH=8 / NREQ=4 sizing
package fifo_arb_pkg;

  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int idx_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  localparam int DEF_NREQ  = 4;
  localparam int DEF_DEPTH = 8;

  typedef logic [credit_w(DEF_DEPTH)-1:0] credit_t;
  typedef logic [idx_w(DEF_NREQ)-1:0]     req_idx_t;

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   elig_i   : eligible requesters
//   ptr_i    : requester with highest priority this cycle
//   valid_o  : at least one requester eligible
//   winner_o : first eligible index at or above ptr_i, wrapping to 0
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] elig_i,
  input  logic [IW-1:0]   ptr_i,
  output logic            valid_o,
  output logic [IW-1:0]   winner_o
);

  // Lower copy keeps only bits at/above the pointer; upper copy is the
  // unmasked vector, so a plain LSB-first search covers the wrap.
  logic [2*NREQ-1:0] dbl;
  logic              found;

  always_comb begin
    dbl = '0;
    for (int i = 0; i < NREQ; i++) begin
      dbl[i]        = elig_i[i] & (IW'(i) >= ptr_i);
      dbl[i + NREQ] = elig_i[i];
    end
  end

  always_comb begin
    valid_o  = |elig_i;
    winner_o = '0;
    found    = 1'b0;
    for (int i = 0; i < 2*NREQ; i++) begin
      if (dbl[i] && !found) begin
        found    = 1'b1;
        winner_o = IW'((i >= NREQ) ? (i - NREQ) : i);
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among NREQ producers.
//   clk, rst        : clock, async active-high reset (reset the FIFO with it)
//   req, req_data   : per-requester request (held until ack) and word
//   ack             : one-hot pulse, that requester's word is being pushed
//   fifo_push/write : registered push strobe and data to the FIFO
//   fifo_pop/empty  : consumer pop and FIFO empty, observed for credits
//   grant_id        : index of current/last winner
//   credits         : free FIFO slots as tracked here
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int IW    = idx_w(NREQ),
  localparam int CW    = credit_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  output logic                  fifo_push,
  output logic [WIDTH-1:0]      fifo_write,
  input  logic                  fifo_pop,
  input  logic                  fifo_empty,
  output logic [IW-1:0]         grant_id,
  output logic [CW-1:0]         credits
);

  logic [NREQ-1:0]  ack_q, ack_d;
  logic             push_q, push_d;
  logic [WIDTH-1:0] write_q, write_d;
  logic [IW-1:0]    gid_q, gid_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cred_q, cred_d;

  logic [NREQ-1:0]  elig;
  logic             pick_vld, grant, inc;
  logic [IW-1:0]    winner;

  // A requester being acked still shows req this cycle; mask it so the
  // same word is not granted twice.
  assign elig = req & ~ack_q;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .elig_i  (elig),
    .ptr_i   (ptr_q),
    .valid_o (pick_vld),
    .winner_o(winner)
  );

  assign grant = pick_vld & (cred_q != '0);
  assign inc   = fifo_pop & ~fifo_empty;

  always_comb begin
    ack_d   = '0;
    push_d  = grant;
    write_d = write_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    cred_d  = cred_q;
    if (grant) begin
      ack_d[winner] = 1'b1;
      write_d       = req_data[winner*WIDTH +: WIDTH];
      gid_d         = winner;
      ptr_d         = (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
    end
    if (grant && !inc)      cred_d = cred_q - 1'b1;
    else if (!grant && inc) cred_d = cred_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q   <= '0;
      push_q  <= 1'b0;
      write_q <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
      cred_q  <= CW'(DEPTH);
    end else begin
      ack_q   <= ack_d;
      push_q  <= push_d;
      write_q <= write_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      cred_q  <= cred_d;
    end
  end

  // A pop that would free more slots than the FIFO has means the FIFO and
  // this counter have drifted apart.
  always_ff @(posedge clk) begin
    if (!rst && inc && !grant) assert (cred_q != CW'(DEPTH));
  end

  assign ack        = ack_q;
  assign fifo_push  = push_q;
  assign fifo_write = write_q;
  assign grant_id   = gid_q;
  assign credits    = cred_q;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
module tb_fifo_push_arbiter;
  localparam int N = 4, W = 8, D = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   ack;
  logic           fifo_push;
  logic [W-1:0]   fifo_write;
  logic           fifo_pop = 1'b0;
  logic           fifo_empty = 1'b1;
  logic [1:0]     grant_id;
  logic [3:0]     credits;

  fifo_push_arbiter #(.NREQ(N), .WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .fifo_push(fifo_push), .fifo_write(fifo_write), .fifo_pop(fifo_pop),
    .fifo_empty(fifo_empty), .grant_id(grant_id), .credits(credits)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // FIFO behind the arbiter (holds what the DUT pushed) and the words the
  // reference model says should have been pushed, in order.
  logic [W-1:0] fq[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_pop;

  // Reference model state
  int           m_ptr, m_cred, m_gid;
  logic [N-1:0] m_ack;
  logic         m_push;
  logic [W-1:0] m_write;

  task automatic model_reset();
    m_ptr = 0; m_cred = D; m_gid = 0; m_ack = '0; m_push = 1'b0; m_write = '0;
    fq.delete(); exp_q.delete(); fifo_empty = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; fifo_pop = 1'b0;
    #1 model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One clock: model evaluates the spec's rules on the pre-edge inputs, the
  // FIFO captures/pops, then DUT outputs are compared to the model.
  task automatic step();
    int win, c;
    logic inc, pre_push;
    logic [W-1:0] pre_w, e;
    logic [N-1:0] elig;
    elig = req & ~m_ack;
    win = -1;
    if (elig != '0 && m_cred > 0)
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (win < 0 && elig[c]) win = c;
      end
    inc = fifo_pop && (fq.size() > 0);
    pre_push = fifo_push; pre_w = fifo_write;
    @(posedge clk);
    if (inc) begin
      last_pop = fq.pop_front();
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++; $display("FAIL pop_data got %h want <nothing>", last_pop);
      end else begin
        e = exp_q.pop_front();
        if (last_pop !== e) begin n_bad++; $display("FAIL pop_data got %h want %h", last_pop, e); end
      end
    end
    if (pre_push) fq.push_back(pre_w);
    if (m_push) exp_q.push_back(m_write);
    m_cred = m_cred - ((win >= 0) ? 1 : 0) + (inc ? 1 : 0);
    m_ack = '0; m_push = (win >= 0);
    if (win >= 0) begin
      m_ack[win] = 1'b1; m_write = req_data[win*W +: W]; m_gid = win; m_ptr = (win + 1) % N;
    end
    #1 fifo_empty = (fq.size() == 0);
    n_cmp++; if (fq.size() > D) begin n_bad++; $display("FAIL fifo_overflow got %0d want <=%0d", fq.size(), D); end
    n_cmp++; if (ack !== m_ack) begin n_bad++; $display("FAIL ack got %b want %b", ack, m_ack); end
    n_cmp++; if (fifo_push !== m_push) begin n_bad++; $display("FAIL fifo_push got %b want %b", fifo_push, m_push); end
    n_cmp++; if (fifo_write !== m_write) begin n_bad++; $display("FAIL fifo_write got %h want %h", fifo_write, m_write); end
    n_cmp++; if (grant_id !== 2'(m_gid)) begin n_bad++; $display("FAIL grant_id got %0d want %0d", grant_id, m_gid); end
    n_cmp++; if (credits !== 4'(m_cred)) begin n_bad++; $display("FAIL credits got %0d want %0d", credits, m_cred); end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (ack !== 4'b0 || fifo_push !== 1'b0 || fifo_write !== 8'h00) begin
      n_bad++; $display("FAIL reset_outs got ack=%b push=%b wr=%h want 0/0/00", ack, fifo_push, fifo_write); end
    n_cmp++; if (credits !== 4'd8 || grant_id !== 2'd0) begin
      n_bad++; $display("FAIL reset_cred got cred=%0d gid=%0d want 8/0", credits, grant_id); end
    repeat (3) step();
    n_cmp++; if (credits !== 4'd8 || ack !== 4'b0) begin
      n_bad++; $display("FAIL idle_after_reset got cred=%0d ack=%b want 8/0000", credits, ack); end
  endtask

  task automatic test_single();
    int acks = 0;
    do_reset();
    req_data = {8'h00, 8'hA5, 8'h00, 8'h00}; req = 4'b0100;
    repeat (6) begin step(); if (ack[2]) acks++; end
    req = '0;
    n_cmp++; if (acks != 3) begin n_bad++; $display("FAIL single_acks got %0d want 3", acks); end
    n_cmp++; if (credits !== 4'd5) begin n_bad++; $display("FAIL single_cred got %0d want 5", credits); end
    fifo_pop = 1'b1;
    repeat (3) begin
      step();
      n_cmp++; if (last_pop !== 8'hA5) begin n_bad++; $display("FAIL single_readback got %h want a5", last_pop); end
    end
    fifo_pop = 1'b0; step();
    n_cmp++; if (credits !== 4'd8) begin n_bad++; $display("FAIL single_drain_cred got %0d want 8", credits); end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10}; req = 4'hF;
    for (int i = 0; i < 8; i++) begin
      step();
      n_cmp++; if (grant_id !== 2'(i % 4) || ack !== 4'(1 << (i % 4))) begin
        n_bad++; $display("FAIL rr_order got gid=%0d ack=%b want gid=%0d", grant_id, ack, i % 4); end
    end
    n_cmp++; if (credits !== 4'd0) begin n_bad++; $display("FAIL rr_full_cred got %0d want 0", credits); end
    repeat (2) begin
      step();
      n_cmp++; if (ack !== 4'b0) begin n_bad++; $display("FAIL rr_stall_ack got %b want 0000", ack); end
    end
  endtask

  task automatic test_full_stall();
    fifo_pop = 1'b1; step(); fifo_pop = 1'b0; step();
    n_cmp++; if (grant_id !== 2'd0 || credits !== 4'd0) begin
      n_bad++; $display("FAIL stall_prep got gid=%0d cred=%0d want 0/0", grant_id, credits); end
    req = 4'b1010;
    repeat (3) step();
    fifo_pop = 1'b1; step(); fifo_pop = 1'b0;
    n_cmp++; if (credits !== 4'd1) begin n_bad++; $display("FAIL resume_cred got %0d want 1", credits); end
    step();
    n_cmp++; if (ack !== 4'b0010 || grant_id !== 2'd1 || credits !== 4'd0) begin
      n_bad++; $display("FAIL resume_grant got ack=%b gid=%0d cred=%0d want 0010/1/0", ack, grant_id, credits); end
    req = 4'b1000;
    step();
    n_cmp++; if (ack !== 4'b0) begin n_bad++; $display("FAIL req3_waits got %b want 0000", ack); end
    fifo_pop = 1'b1; step(); fifo_pop = 1'b0; step();
    n_cmp++; if (ack !== 4'b1000 || grant_id !== 2'd3) begin
      n_bad++; $display("FAIL req3_grant got ack=%b gid=%0d want 1000/3", ack, grant_id); end
    req = '0;
  endtask

  task automatic test_simul_push_pop();
    int guard = 0;
    fifo_pop = 1'b1; repeat (4) step();
    n_cmp++; if (credits !== 4'd4) begin n_bad++; $display("FAIL simul_prep got %0d want 4", credits); end
    req_data = {8'h13, 8'h12, 8'h11, 8'h10}; req = 4'b0001;
    step(); req = '0;
    n_cmp++; if (credits !== 4'd4 || ack !== 4'b0001) begin
      n_bad++; $display("FAIL simul_cred got cred=%0d ack=%b want 4/0001", credits, ack); end
    while ((fq.size() > 0 || fifo_push) && guard < 20) begin step(); guard++; end
    n_cmp++; if (guard >= 20) begin n_bad++; $display("FAIL drain_timeout got %0d want <20", guard); end
    repeat (2) step();
    fifo_pop = 1'b0;
    n_cmp++; if (credits !== 4'd8 || fifo_empty !== 1'b1) begin
      n_bad++; $display("FAIL empty_pop got cred=%0d empty=%b want 8/1", credits, fifo_empty); end
  endtask

  task automatic test_withdrawn();
    int guard = 0, sz;
    logic seen = 1'b0;
    req_data = {8'h43, 8'h42, 8'h41, 8'h40}; req = 4'hF;
    while (m_cred != 0 && guard < 20) begin step(); guard++; end
    req = '0; step();
    sz = fq.size();
    req = 4'b0001; step(); seen |= ack[0];
    req = '0; step(); seen |= ack[0]; step(); seen |= ack[0];
    n_cmp++; if (seen !== 1'b0 || fifo_push !== 1'b0) begin
      n_bad++; $display("FAIL withdraw_ack got ack0=%b push=%b want 0/0", seen, fifo_push); end
    n_cmp++; if (fq.size() != sz) begin n_bad++; $display("FAIL withdraw_fifo got %0d want %0d", fq.size(), sz); end
    fifo_pop = 1'b1; guard = 0;
    while (fq.size() > 0 && guard < 20) begin step(); guard++; end
    fifo_pop = 1'b0; step();
    n_cmp++; if (credits !== 4'd8) begin n_bad++; $display("FAIL withdraw_drain got %0d want 8", credits); end
  endtask

  task automatic test_reset_mid();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (ack !== 4'b0 || fifo_push !== 1'b0 || credits !== 4'd8 || grant_id !== 2'd0) begin
      n_bad++; $display("FAIL async_reset got ack=%b push=%b cred=%0d gid=%0d want 0/0/8/0",
                        ack, fifo_push, credits, grant_id); end
    req = '0; fifo_pop = 1'b0; model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();
    n_cmp++; if (ack !== 4'b0 || credits !== 4'd8) begin
      n_bad++; $display("FAIL post_reset got ack=%b cred=%0d want 0000/8", ack, credits); end
  endtask

  task automatic test_random();
    int guard = 0;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc == 700) test_reset_mid();
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          if ($urandom_range(1, 0) == 1) req[i] = 1'b0;
          else req_data[i*W +: W] = 8'($urandom);
        end else if (!req[i]) begin
          if ($urandom_range(2, 0) == 0) begin req[i] = 1'b1; req_data[i*W +: W] = 8'($urandom); end
        end else if ($urandom_range(49, 0) == 0) req[i] = 1'b0;
      end
      fifo_pop = ($urandom_range(2, 0) != 0);
      step();
    end
    req = '0; fifo_pop = 1'b1;
    while ((fq.size() > 0 || fifo_push) && guard < 30) begin step(); guard++; end
    fifo_pop = 1'b0; step();
    n_cmp++; if (exp_q.size() != 0 || credits !== 4'd8) begin
      n_bad++; $display("FAIL random_end got left=%0d cred=%0d want 0/8", exp_q.size(), credits); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_simul_push_pop();
    test_withdrawn();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
